npc_bpred: RTL and testbench
============================

Name: npc_bpred

Overview:
- Registered next-PC generator for the fetch stage. Holds the fetch PC.
- Predicts control flow with a parametrised direct-mapped BTB that has 2-bit saturating counters.
- Resolves actual branch/jump outcomes from execute and redirects fetch on a mispredict.
- Generalises the combinational next-PC logic: adds width parameters, a JALR target LSB clear, stall handling, prediction and a mispredict counter.

Parameters:
- XLEN, 32, address/data width.
- BTB_DEPTH, 16, number of BTB entries; power of two, at least 2; IDX = log2(BTB_DEPTH).
- RESET_VEC, 32'h0000_0000, PC value after reset.
- CNT_W, 32, width of the mispredict counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold fetch PC (decode/hazard stall).
- pc  out  XLEN  current fetch PC (registered).
- pred_taken  out  1  prediction for the current pc (combinational from pc and BTB state).
- pred_target  out  XLEN  predicted target for the current pc; equals pc+4 when not taken.
- ex_valid  in  1  execute stage holds a valid instruction this cycle.
- ex_is_ctrl  in  1  the execute instruction is a branch, JAL or JALR.
- ex_pc  in  XLEN  PC of the execute instruction.
- ex_br_taken  in  1  actual taken outcome.
- ex_alucode  in  6  ALU code; ALU_JAL and ALU_JALR come from define.vh.
- ex_imm  in  XLEN  immediate.
- ex_rs1_data  in  XLEN  rs1 operand.
- ex_pred_taken  in  1  prediction that was carried down the pipe with this instruction.
- ex_pred_target  in  XLEN  predicted target that was carried down the pipe.
- redirect  out  1  one-cycle pulse when execute detects a mispredict; the pipe flushes younger instructions.
- mispredict_cnt  out  CNT_W  saturating count of mispredicts.

Behaviour:

Reset (synchronous, takes priority over everything):
- pc=RESET_VEC, redirect=0, mispredict_cnt=0.
- Every BTB valid=0; every counter=2'b01.
- Reset asserted mid-operation discards any in-flight redirect or update.

Actual next PC (combinational, execute side):
- Taken and ex_alucode==ALU_JALR: (ex_rs1_data+ex_imm) & ~1.
- Taken, any other code (JAL, conditional branch, default): ex_pc+ex_imm.
- Not taken: ex_pc+4.
- All additions are modulo 2^XLEN; no overflow flag.

Mispredict condition:
- mispredict = ex_valid & ex_is_ctrl & (ex_br_taken != ex_pred_taken | (ex_br_taken & actual_target != ex_pred_target)).
- ex_is_ctrl=0 never causes a mispredict.

PC register update, in priority order:
- rst.
- mispredict: pc <= actual next PC. This applies even when stall=1; redirect overrides stall.
- stall: pc holds.
- Otherwise: pc <= pred_target.

redirect output:
- Registered: redirect=1 in the cycle after the mispredict is observed, i.e. coincident with the corrected pc.
- Otherwise 0.

BTB lookup (combinational):
- Index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
- hit = valid & tag match.
- pred_taken = hit & counter[1].
- pred_target = stored target when pred_taken, else pc+4.

BTB update (at the clock edge, when ex_valid & ex_is_ctrl & !rst; independent of stall):
- Taken and hit: target <= actual target; counter saturating increment (max 2'b11).
- Taken and miss: allocate or overwrite the entry (aliasing evicts); valid=1, tag, target, counter=2'b10.
- Not taken and hit: counter saturating decrement (min 2'b00); entry stays valid.
- Not taken and miss: no change.
- A lookup in the same cycle as a write to the same index reads the old contents; no bypass.

mispredict_cnt:
- +1 per mispredict cycle; saturates at all-ones.

Test Plan:
1. Reset then run 4 cycles with no ex_valid: pc = 0, 4, 8, 0xC; pred_taken=0 throughout; mispredict_cnt=0.
2. JAL mispredict and relearn:
   - Stimulus: ex_pc=0x10, ALU_JAL, imm=0x40, taken, pred_taken=0.
   - Next cycle: redirect=1, pc=0x50, mispredict_cnt=1.
   - When pc later returns to 0x10: pred_taken=1, pred_target=0x50.
3. JALR LSB clear:
   - Stimulus: rs1=0x1001, imm=0x2, taken, pred_target=0x1002.
   - Actual target is 0x1002, so no redirect.
   - Repeat with pred_target=0x1003: redirect, pc=0x1002.
4. Stall vs redirect:
   - stall=1 with no mispredict: pc holds for 3 cycles.
   - stall=1 with a mispredict on ex_pc=0x20, not taken, pred_taken=1: pc=0x24 next cycle.
5. Counter hysteresis and aliasing, BTB_DEPTH=16:
   - Branch at 0x30 taken twice (counter=2'b11), then not-taken once: still predicted taken.
   - Second not-taken: predicted not taken.
   - Taken JAL at 0x70 (same index, different tag) evicts the entry; 0x30 then misses.
6. Reset mid-operation: rst asserted in the same cycle as a mispredict → next cycle pc=RESET_VEC, redirect=0, BTB cleared (previously learned 0x10 no longer predicted).

Source files
------------

// File: rtl/npc_bpred.sv
// Fetch-stage next-PC generator with a direct-mapped BTB predictor.
// Resolves execute outcomes, redirects on mispredict and counts them.
package npc_bpred_pkg;
    localparam logic [5:0] ALU_JAL  = 6'd30;
    localparam logic [5:0] ALU_JALR = 6'd31;
endpackage

module npc_bpred
    import npc_bpred_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              BTB_DEPTH = 16,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    output logic [XLEN-1:0]  pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_ctrl,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_br_taken,
    input  logic [5:0]       ex_alucode,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs1_data,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             redirect,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic             btb_valid  [BTB_DEPTH];
    logic [TAG_W-1:0] btb_tag    [BTB_DEPTH];
    logic [XLEN-1:0]  btb_target [BTB_DEPTH];
    logic [1:0]       btb_cnt    [BTB_DEPTH];

    logic [IDX-1:0]   rd_idx;
    logic [IDX-1:0]   ex_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] ex_tag;
    logic             rd_hit;
    logic             ex_hit;
    logic             ex_upd;
    logic             mispredict;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  actual_next;

    assign rd_idx = pc[IDX+1:2];
    assign rd_tag = pc[XLEN-1:IDX+2];
    assign rd_hit = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);

    assign pred_taken  = rd_hit && btb_cnt[rd_idx][1];
    assign pred_target = pred_taken ? btb_target[rd_idx] : pc + FOUR;

    assign ex_idx = ex_pc[IDX+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX+2];
    assign ex_hit = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);

    always_comb begin
        jalr_sum    = ex_rs1_data + ex_imm;
        actual_next = ex_pc + FOUR;
        if (ex_br_taken) begin
            if (ex_alucode == ALU_JALR)
                actual_next = {jalr_sum[XLEN-1:1], 1'b0};
            else
                actual_next = ex_pc + ex_imm;
        end
    end

    assign ex_upd     = ex_valid & ex_is_ctrl;
    assign mispredict = ex_upd &
        ((ex_br_taken != ex_pred_taken) |
         (ex_br_taken & (actual_next != ex_pred_target)));

    // Redirect beats stall so a flushed pipe never fetches down the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_VEC;
            redirect       <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            redirect <= mispredict;
            if (mispredict)
                pc <= actual_next;
            else if (!stall)
                pc <= pred_target;
            if (mispredict && (mispredict_cnt != '1))
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_valid[i] <= 1'b0;
                btb_cnt[i]   <= 2'b01;
            end
        end else if (ex_upd) begin
            if (ex_br_taken) begin
                if (ex_hit) begin
                    btb_target[ex_idx] <= actual_next;
                    if (btb_cnt[ex_idx] != 2'b11)
                        btb_cnt[ex_idx] <= btb_cnt[ex_idx] + 2'b01;
                end else begin
                    btb_valid[ex_idx]  <= 1'b1;
                    btb_tag[ex_idx]    <= ex_tag;
                    btb_target[ex_idx] <= actual_next;
                    btb_cnt[ex_idx]    <= 2'b10;
                end
            end else if (ex_hit && (btb_cnt[ex_idx] != 2'b00)) begin
                btb_cnt[ex_idx] <= btb_cnt[ex_idx] - 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_npc_bpred.sv
// Self-checking bench for npc_bpred: vector table plus hand sequences.
// Expected post-edge state is queued on drive and popped after the edge.
module tb_npc_bpred;
    import npc_bpred_pkg::*;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam logic [5:0] BR  = 6'd0;
    localparam logic [5:0] JAL = ALU_JAL;
    localparam logic [5:0] JLR = ALU_JALR;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic [31:0] pc, pred_target;
    logic        pred_taken;
    logic        ex_valid, ex_is_ctrl, ex_br_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_pred_target;
    logic [5:0]  ex_alucode;
    logic        redirect;
    logic [31:0] mispredict_cnt;

    always #5 clk = ~clk;

    npc_bpred dut (
        .clk(clk), .rst(rst), .stall(stall),
        .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_ctrl(ex_is_ctrl), .ex_pc(ex_pc),
        .ex_br_taken(ex_br_taken), .ex_alucode(ex_alucode),
        .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect(redirect), .mispredict_cnt(mispredict_cnt)
    );

    typedef struct {
        logic rst, stall, exv, ctrl;
        logic [31:0] xpc;
        logic tk;
        logic [5:0] alu;
        logic [31:0] imm, rs1;
        logic ptk;
        logic [31:0] ptg;
        logic [31:0] e_pc;
        logic e_red;
        logic [31:0] e_cnt;
        logic e_ptk;
        logic [31:0] e_ptg;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic red;
        logic [31:0] cnt;
        logic ptk;
        logic [31:0] ptg;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[23];

    task automatic chk(input string nm, input int step,
                       input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h required %h",
                     nm, step, act, req);
        end
    endtask

    task automatic apply(input int step, input vec_t v);
        exp_t e;
        rst            = v.rst;
        stall          = v.stall;
        ex_valid       = v.exv;
        ex_is_ctrl     = v.ctrl;
        ex_pc          = v.xpc;
        ex_br_taken    = v.tk;
        ex_alucode     = v.alu;
        ex_imm         = v.imm;
        ex_rs1_data    = v.rs1;
        ex_pred_taken  = v.ptk;
        ex_pred_target = v.ptg;
        sbq.push_back('{v.e_pc, v.e_red, v.e_cnt, v.e_ptk, v.e_ptg});
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard step %0d: queue empty", step);
        end else begin
            e = sbq.pop_front();
            chk("pc", step, pc, e.pc);
            chk("redirect", step, {31'd0, redirect}, {31'd0, e.red});
            chk("mispredict_cnt", step, mispredict_cnt, e.cnt);
            chk("pred_taken", step, {31'd0, pred_taken}, {31'd0, e.ptk});
            chk("pred_target", step, pred_target, e.ptg);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_is_ctrl = 1'b0;
        ex_pc = '0; ex_br_taken = 1'b0; ex_alucode = '0; ex_imm = '0;
        ex_rs1_data = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;

        // reset and free-running fetch
        tbl[0]  = '{Y,N,N,N,32'h0,N,BR,32'h0,32'h0,N,32'h0,
                    32'h0,N,32'd0,N,32'h4};
        tbl[1]  = '{N,N,N,N,32'h0,N,BR,32'h0,32'h0,N,32'h0,
                    32'h4,N,32'd0,N,32'h8};
        tbl[2]  = '{N,N,N,N,32'h0,N,BR,32'h0,32'h0,N,32'h0,
                    32'h8,N,32'd0,N,32'hC};
        tbl[3]  = '{N,N,N,N,32'h0,N,BR,32'h0,32'h0,N,32'h0,
                    32'hC,N,32'd0,N,32'h10};
        // JAL mispredict, then return to 0x10 and see it learned
        tbl[4]  = '{N,N,Y,Y,32'h10,Y,JAL,32'h40,32'h0,N,32'h0,
                    32'h50,Y,32'd1,N,32'h54};
        tbl[5]  = '{N,N,Y,Y,32'hC,N,BR,32'h0,32'h0,Y,32'h0,
                    32'h10,Y,32'd2,Y,32'h50};
        tbl[6]  = '{N,N,N,N,32'h0,N,BR,32'h0,32'h0,N,32'h0,
                    32'h50,N,32'd2,N,32'h54};
        // JALR LSB clear: matching, then wrong predicted target
        tbl[7]  = '{N,N,Y,Y,32'h100,Y,JLR,32'h2,32'h1001,Y,32'h1002,
                    32'h54,N,32'd2,N,32'h58};
        tbl[8]  = '{N,N,Y,Y,32'h100,Y,JLR,32'h2,32'h1001,Y,32'h1003,
                    32'h1002,Y,32'd3,N,32'h1006};
        // stall holds, redirect overrides stall
        tbl[9]  = '{N,Y,N,N,32'h0,N,BR,32'h0,32'h0,N,32'h0,
                    32'h1002,N,32'd3,N,32'h1006};
        tbl[10] = '{N,Y,N,N,32'h0,N,BR,32'h0,32'h0,N,32'h0,
                    32'h1002,N,32'd3,N,32'h1006};
        tbl[11] = '{N,Y,N,N,32'h0,N,BR,32'h0,32'h0,N,32'h0,
                    32'h1002,N,32'd3,N,32'h1006};
        tbl[12] = '{N,Y,Y,Y,32'h20,N,BR,32'h0,32'h0,Y,32'h0,
                    32'h24,Y,32'd4,N,32'h28};
        // hysteresis on branch at 0x30, then alias eviction from 0x70
        tbl[13] = '{N,N,Y,Y,32'h30,Y,BR,32'h100,32'h0,Y,32'h130,
                    32'h28,N,32'd4,N,32'h2C};
        tbl[14] = '{N,N,Y,Y,32'h30,Y,BR,32'h100,32'h0,Y,32'h130,
                    32'h2C,N,32'd4,N,32'h30};
        tbl[15] = '{N,N,Y,Y,32'h30,N,BR,32'h100,32'h0,N,32'h0,
                    32'h30,N,32'd4,Y,32'h130};
        tbl[16] = '{N,Y,Y,Y,32'h30,N,BR,32'h100,32'h0,N,32'h0,
                    32'h30,N,32'd4,N,32'h34};
        tbl[17] = '{N,Y,Y,Y,32'h70,Y,JAL,32'h10,32'h0,N,32'h0,
                    32'h80,Y,32'd5,N,32'h84};
        tbl[18] = '{N,N,Y,Y,32'h2C,N,BR,32'h0,32'h0,Y,32'h0,
                    32'h30,Y,32'd6,N,32'h34};
        // reset together with a mispredict clears everything
        tbl[19] = '{Y,N,Y,Y,32'h40,Y,JAL,32'h4,32'h0,N,32'h0,
                    32'h0,N,32'd0,N,32'h4};
        tbl[20] = '{N,N,Y,Y,32'hC,N,BR,32'h0,32'h0,Y,32'h0,
                    32'h10,Y,32'd1,N,32'h14};
        // non-control or invalid execute never redirects
        tbl[21] = '{N,N,Y,N,32'h10,Y,JAL,32'h40,32'h0,N,32'h0,
                    32'h14,N,32'd1,N,32'h18};
        tbl[22] = '{N,N,N,Y,32'h10,Y,JAL,32'h40,32'h0,N,32'h0,
                    32'h18,N,32'd1,N,32'h1C};

        for (int i = 0; i < 23; i++)
            apply(i, tbl[i]);

        // fetch follows a learned target
        apply(100, '{N,N,Y,Y,32'h20,Y,BR,32'h1E0,32'h0,Y,32'h200,
                     32'h1C,N,32'd1,N,32'h20});
        apply(101, '{N,N,N,N,32'h0,N,BR,32'h0,32'h0,N,32'h0,
                     32'h20,N,32'd1,Y,32'h200});
        apply(102, '{N,N,N,N,32'h0,N,BR,32'h0,32'h0,N,32'h0,
                     32'h200,N,32'd1,N,32'h204});
        // counter floors at 00 and the entry stays valid
        for (int i = 0; i < 3; i++)
            apply(103 + i, '{N,N,Y,Y,32'h20,N,BR,32'h1E0,32'h0,N,32'h0,
                             32'h204 + 32'(4*i),N,32'd1,N,
                             32'h208 + 32'(4*i)});
        apply(106, '{N,N,Y,Y,32'h20,Y,BR,32'h1E0,32'h0,Y,32'h200,
                     32'h210,N,32'd1,N,32'h214});
        apply(107, '{N,N,Y,Y,32'h1C,N,BR,32'h0,32'h0,Y,32'h0,
                     32'h20,Y,32'd2,N,32'h24});

        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: %0d entries left", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
